// File: rtl/s27_bist_ctrl.sv
// BIST sequencer for the s27 benchmark core: flushes core state with a fixed vector,
// drives LFSR patterns, compacts G17 into a CCITT MISR and reports the signature check.
module s27_bist_ctrl #(
  parameter int unsigned  NPAT      = 64,
  parameter int unsigned  INIT_CYC  = 4,
  parameter logic [3:0]   INIT_VEC  = 4'b0110,
  parameter logic [3:0]   LFSR_SEED = 4'b0001,
  parameter logic [15:0]  GOLDEN    = 16'h0000
) (
  input  logic        ck_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        cut_g17_i,
  output logic [3:0]  cut_g_o,
  output logic        cut_ce_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] sig_o
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_e;

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYC - 1);
  localparam logic [15:0] NPAT_LAST = 16'(NPAT - 1);
  localparam bit          SKIP_RUN  = (NPAT == 0);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  lfsr_q, lfsr_d;
  logic [15:0] sig_q, sig_d;
  logic [3:0]  cut_g_q, cut_g_d;
  logic        cut_ce_q, cut_ce_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic [3:0]  lfsr_next;
  logic [15:0] misr_next;

  assign lfsr_next = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  assign misr_next = {sig_q[14:0], 1'b0}
                   ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                   ^ {15'b0, cut_g17_i};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    sig_d    = sig_q;
    cut_g_d  = 4'b0000;
    cut_ce_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    pass_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_INIT;
          lfsr_d  = LFSR_SEED;
          sig_d   = 16'h0000;
          cnt_d   = 16'h0000;
        end
      end
      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          cnt_d   = 16'h0000;
          state_d = SKIP_RUN ? S_DONE : S_RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        sig_d  = misr_next;
        lfsr_d = lfsr_next;
        if (cnt_q == NPAT_LAST) begin
          cnt_d   = 16'h0000;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight off a flop.
    case (state_d)
      S_INIT: begin
        cut_g_d  = INIT_VEC;
        cut_ce_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_RUN: begin
        cut_g_d  = lfsr_d;
        cut_ce_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
        pass_d = (sig_d == GOLDEN);
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'h0000;
      lfsr_q   <= LFSR_SEED;
      sig_q    <= 16'h0000;
      cut_g_q  <= 4'b0000;
      cut_ce_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      sig_q    <= sig_d;
      cut_g_q  <= cut_g_d;
      cut_ce_q <= cut_ce_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign cut_g_o  = cut_g_q;
  assign cut_ce_o = cut_ce_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign pass_o   = pass_q;
  assign sig_o    = sig_q;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Directed bench for s27_bist_ctrl: vector table for sequencing and restart, plus
// hand-written sequences for MISR values, PASS, NPAT=0, MISR feedback and reset abort.
module tb_s27_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: NPAT=4, INIT_CYC=2, GOLDEN=0, G17 driven from the table
  logic start_a = 1'b0, g17_a = 1'b0;
  logic [3:0] g_a; logic ce_a, busy_a, done_a, pass_a; logic [15:0] sig_a;
  // B/C: NPAT=3, INIT_CYC=2, G17 tied 1, GOLDEN 7 / 0; D: NPAT=0
  logic start_b = 1'b0;
  logic [3:0] g_b, g_c, g_d; logic ce_b, ce_c, ce_d;
  logic busy_b, busy_c, busy_d, done_b, done_c, done_d, pass_b, pass_c, pass_d;
  logic [15:0] sig_b, sig_c, sig_d;
  // E: NPAT=17, INIT_CYC=1, for MISR feedback
  logic start_e = 1'b0, g17_e = 1'b0;
  logic [3:0] g_e; logic ce_e, busy_e, done_e, pass_e; logic [15:0] sig_e;

  s27_bist_ctrl #(.NPAT(4), .INIT_CYC(2)) u_a (
    .ck_i(clk), .rst_i(rst), .start_i(start_a), .cut_g17_i(g17_a),
    .cut_g_o(g_a), .cut_ce_o(ce_a), .busy_o(busy_a), .done_o(done_a),
    .pass_o(pass_a), .sig_o(sig_a));
  s27_bist_ctrl #(.NPAT(3), .INIT_CYC(2), .GOLDEN(16'h0007)) u_b (
    .ck_i(clk), .rst_i(rst), .start_i(start_b), .cut_g17_i(1'b1),
    .cut_g_o(g_b), .cut_ce_o(ce_b), .busy_o(busy_b), .done_o(done_b),
    .pass_o(pass_b), .sig_o(sig_b));
  s27_bist_ctrl #(.NPAT(3), .INIT_CYC(2), .GOLDEN(16'h0000)) u_c (
    .ck_i(clk), .rst_i(rst), .start_i(start_b), .cut_g17_i(1'b1),
    .cut_g_o(g_c), .cut_ce_o(ce_c), .busy_o(busy_c), .done_o(done_c),
    .pass_o(pass_c), .sig_o(sig_c));
  s27_bist_ctrl #(.NPAT(0), .INIT_CYC(2)) u_d (
    .ck_i(clk), .rst_i(rst), .start_i(start_b), .cut_g17_i(1'b1),
    .cut_g_o(g_d), .cut_ce_o(ce_d), .busy_o(busy_d), .done_o(done_d),
    .pass_o(pass_d), .sig_o(sig_d));
  s27_bist_ctrl #(.NPAT(17), .INIT_CYC(1)) u_e (
    .ck_i(clk), .rst_i(rst), .start_i(start_e), .cut_g17_i(g17_e),
    .cut_g_o(g_e), .cut_ce_o(ce_e), .busy_o(busy_e), .done_o(done_e),
    .pass_o(pass_e), .sig_o(sig_e));

  typedef struct packed {
    logic        start;
    logic        g17;
    logic [3:0]  g;
    logic        ce;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] sig;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // inputs for the cycle ending at the edge, then outputs expected just after it
    tbl[0]  = '{1'b1, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001};
    tbl[4]  = '{1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002};
    tbl[5]  = '{1'b0, 1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0005};
    tbl[6]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h000B};
    tbl[7]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h000B};
    tbl[8]  = '{1'b1, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[9]  = '{1'b1, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[10] = '{1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[11] = '{1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[12] = '{1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[13] = '{1'b0, 1'b0, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[14] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};

    // reset state
    #1;
    check("rst_g",    0, 16'(g_a),    16'h0);
    check("rst_ce",   0, 16'(ce_a),   16'h0);
    check("rst_busy", 0, 16'(busy_a), 16'h0);
    check("rst_done", 0, 16'(done_a), 16'h0);
    check("rst_pass", 0, 16'(pass_a), 16'h0);
    check("rst_sig",  0, sig_a,       16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // table: sequencing, signature, START ignored while busy, restart from DONE
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      start_a = tbl[i].start;
      g17_a   = tbl[i].g17;
      @(posedge clk); #1;
      $display("vec %0d: start=%b g17=%b -> g=%b ce=%b busy=%b done=%b pass=%b sig=%h",
               i, tbl[i].start, tbl[i].g17, g_a, ce_a, busy_a, done_a, pass_a, sig_a);
      check("tbl_g",    i, 16'(g_a),    16'(tbl[i].g));
      check("tbl_ce",   i, 16'(ce_a),   16'(tbl[i].ce));
      check("tbl_busy", i, 16'(busy_a), 16'(tbl[i].busy));
      check("tbl_done", i, 16'(done_a), 16'(tbl[i].done));
      check("tbl_pass", i, 16'(pass_a), 16'(tbl[i].pass));
      check("tbl_sig",  i, sig_a,       tbl[i].sig);
    end
    @(negedge clk) start_a = 1'b0; g17_a = 1'b0;

    // G17=1 for 3 patterns -> 0001,0003,0007; PASS vs GOLDEN 7 and 0; NPAT=0 path
    for (int s = 0; s < 8; s++) begin
      logic [15:0] exp_sig;
      @(negedge clk) start_b = (s == 0);
      @(posedge clk); #1;
      exp_sig = (s <= 2) ? 16'h0000 : (s == 3) ? 16'h0001 : (s == 4) ? 16'h0003 : 16'h0007;
      $display("npat3/npat0 step %0d: sigB=%h busyB=%b doneB=%b passB=%b passC=%b busyD=%b doneD=%b passD=%b",
               s, sig_b, busy_b, done_b, pass_b, pass_c, busy_d, done_d, pass_d);
      check("b_busy", s, 16'(busy_b), 16'(s <= 4));
      check("b_done", s, 16'(done_b), 16'(s >= 5));
      check("b_sig",  s, sig_b,       exp_sig);
      check("b_pass", s, 16'(pass_b), 16'(s >= 5));
      check("c_sig",  s, sig_c,       exp_sig);
      check("c_pass", s, 16'(pass_c), 16'h0);
      check("d_busy", s, 16'(busy_d), 16'(s <= 1));
      check("d_done", s, 16'(done_d), 16'(s >= 2));
      check("d_pass", s, 16'(pass_d), 16'(s >= 2));
      check("d_sig",  s, sig_d,       16'h0);
    end
    @(negedge clk) start_b = 1'b0;

    // MISR frozen in INIT, then shift a single 1 up to bit 15 and fold it back
    @(negedge clk) start_e = 1'b1;
    @(posedge clk);
    @(negedge clk) begin start_e = 1'b0; g17_e = 1'b1; end
    @(posedge clk); #1;
    $display("misr init: g=%b sig=%h", g_e, sig_e);
    check("e_init_sig", 0, sig_e,       16'h0);
    check("e_first_g",  0, 16'(g_e),    16'h1);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk) g17_e = (k == 0);
      @(posedge clk); #1;
      $display("misr step %0d: g17=%b sig=%h done=%b", k, g17_e, sig_e, done_e);
      if (k == 0)  check("e_g_k1",   k, 16'(g_e),    16'h2);
      if (k == 15) check("e_sig8000", k, sig_e,      16'h8000);
      if (k == 16) begin
        check("e_sig1021", k, sig_e,       16'h1021);
        check("e_done",    k, 16'(done_e), 16'h1);
      end
    end
    @(negedge clk) g17_e = 1'b0;

    // reset mid-RUN aborts immediately
    @(negedge clk) begin start_a = 1'b1; g17_a = 1'b1; end
    @(posedge clk);
    @(negedge clk) start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", 0, 16'(busy_a), 16'h1);
    check("pre_rst_sig",  0, sig_a,       16'h0001);
    #2 rst = 1'b1;
    #1;
    $display("reset mid-run: g=%b ce=%b busy=%b done=%b sig=%h", g_a, ce_a, busy_a, done_a, sig_a);
    check("arst_busy", 0, 16'(busy_a), 16'h0);
    check("arst_done", 0, 16'(done_a), 16'h0);
    check("arst_ce",   0, 16'(ce_a),   16'h0);
    check("arst_g",    0, 16'(g_a),    16'h0);
    check("arst_sig",  0, sig_a,       16'h0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_busy", 0, 16'(busy_a), 16'h0);
    check("post_rst_ce",   0, 16'(ce_a),   16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
